// File: rtl/inert_led_monitor.sv
// Board LED readout stage: selects one of NUM_CH signed channels and displays it
// live, as a block average, as a held peak, or frozen, through a saturating slice.
module inert_led_monitor #(
  parameter int NUM_CH   = 3,
  parameter int DATA_W   = 13,
  parameter int LED_W    = 8,
  parameter int LSB_SEL  = 1,
  parameter int AVG_LOG2 = 2,
  parameter bit SAT      = 1'b1,
  localparam int SEL_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     vld,
  input  logic [NUM_CH*DATA_W-1:0] data,
  input  logic [SEL_W-1:0]         ch_sel,
  input  logic [1:0]               mode,
  input  logic                     clr_pk,
  output logic [LED_W-1:0]         LED,
  output logic                     led_upd
);

  localparam int AW = DATA_W + AVG_LOG2;
  localparam logic signed [DATA_W-1:0] LED_MAX = DATA_W'(2**(LED_W-1) - 1);
  localparam logic signed [DATA_W-1:0] LED_MIN = ~LED_MAX;
  localparam logic signed [DATA_W-1:0] PK_MIN  = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    MODE_LIVE = 2'd0,
    MODE_AVG  = 2'd1,
    MODE_PEAK = 2'd2,
    MODE_FRZ  = 2'd3
  } mode_e;

  logic [LED_W-1:0]         r_led;
  logic                     r_upd;
  logic signed [AW-1:0]     r_acc;
  logic [AVG_LOG2-1:0]      r_cnt;
  logic signed [DATA_W-1:0] r_peak;
  logic [SEL_W-1:0]         r_sel_q;
  logic [1:0]               r_mode_q;

  mode_e                    w_mode;
  logic                     w_chg;
  logic signed [DATA_W-1:0] w_s;
  logic signed [AW-1:0]     w_acc_b;
  logic [AVG_LOG2-1:0]      w_cnt_b;
  logic signed [DATA_W-1:0] w_pk_b;
  logic signed [AW-1:0]     w_sum;
  logic signed [DATA_W-1:0] w_mean;
  logic signed [AW-1:0]     w_acc_nxt;
  logic [AVG_LOG2-1:0]      w_cnt_nxt;
  logic signed [DATA_W-1:0] w_peak_nxt;
  logic [LED_W-1:0]         w_led_nxt;
  logic                     w_load;

  function automatic logic [LED_W-1:0] disp(input logic signed [DATA_W-1:0] x);
    logic signed [DATA_W-1:0] y;
    y = x >>> LSB_SEL;
    if (SAT) begin
      if (y > LED_MAX)      y = LED_MAX;
      else if (y < LED_MIN) y = LED_MIN;
    end
    return y[LED_W-1:0];
  endfunction

  assign w_mode = mode_e'(mode);
  assign w_chg  = (ch_sel != r_sel_q) || (mode != r_mode_q);

  always_comb begin
    w_s = data[DATA_W-1:0];
    for (int unsigned k = 1; k < NUM_CH; k++) begin
      if (ch_sel == SEL_W'(k)) w_s = data[k*DATA_W +: DATA_W];
    end
  end

  // A config change clears state before this cycle's sample is applied, so a
  // coincident vld becomes the first sample of the new configuration.
  always_comb begin
    w_acc_b = w_chg ? '0 : r_acc;
    w_cnt_b = w_chg ? '0 : r_cnt;
    w_pk_b  = (w_chg || clr_pk) ? PK_MIN : r_peak;
    w_sum   = w_acc_b + {{AVG_LOG2{w_s[DATA_W-1]}}, w_s};
    w_mean  = DATA_W'(w_sum >>> AVG_LOG2);
  end

  always_comb begin
    w_acc_nxt  = w_acc_b;
    w_cnt_nxt  = w_cnt_b;
    w_peak_nxt = w_pk_b;
    w_led_nxt  = r_led;
    w_load     = 1'b0;
    if (vld) begin
      unique case (w_mode)
        MODE_LIVE: begin
          w_load    = 1'b1;
          w_led_nxt = disp(w_s);
        end
        MODE_AVG: begin
          if (w_cnt_b == '1) begin
            w_load    = 1'b1;
            w_led_nxt = disp(w_mean);
            w_acc_nxt = '0;
            w_cnt_nxt = '0;
          end else begin
            w_acc_nxt = w_sum;
            w_cnt_nxt = w_cnt_b + AVG_LOG2'(1);
          end
        end
        MODE_PEAK: begin
          if (w_s > w_pk_b) begin
            w_peak_nxt = w_s;
            w_load     = 1'b1;
            w_led_nxt  = disp(w_s);
          end
        end
        MODE_FRZ: ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_led    <= '0;
      r_upd    <= 1'b0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_peak   <= PK_MIN;
      r_sel_q  <= '0;
      r_mode_q <= '0;
    end else begin
      r_led    <= w_led_nxt;
      r_upd    <= w_load;
      r_acc    <= w_acc_nxt;
      r_cnt    <= w_cnt_nxt;
      r_peak   <= w_peak_nxt;
      r_sel_q  <= ch_sel;
      r_mode_q <= mode;
    end
  end

  assign LED     = r_led;
  assign led_upd = r_upd;

endmodule

// File: tb/tb_inert_led_monitor.sv
// Scoreboard bench for inert_led_monitor: expected LED loads are queued as
// stimulus is driven and compared whenever led_upd pulses.
module tb_inert_led_monitor;
  localparam int NUM_CH = 3;
  localparam int DATA_W = 13;
  localparam int LED_W  = 8;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic                     vld = 1'b0;
  logic [NUM_CH*DATA_W-1:0] data = '0;
  logic [1:0]               ch_sel = '0;
  logic [1:0]               mode = '0;
  logic                     clr_pk = 1'b0;
  logic [LED_W-1:0]         LED;
  logic                     led_upd;

  int total = 0;
  int bad = 0;
  int upd_cnt = 0;
  int upd_mark;
  logic [7:0] exp_q[$];

  inert_led_monitor #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .LED_W(LED_W),
    .LSB_SEL(1), .AVG_LOG2(2), .SAT(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .vld(vld), .data(data), .ch_sel(ch_sel),
    .mode(mode), .clr_pk(clr_pk), .LED(LED), .led_upd(led_upd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && led_upd) begin
      upd_cnt++;
      check("upd_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("led_val", 32'(LED), 32'(exp_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one vld cycle; consecutive calls give back-to-back strobes.
  task automatic sample(input int v, input int ch);
    logic [31:0] vv;
    vv = v;
    data = 39'({$urandom(), $urandom()});
    data[ch*DATA_W +: DATA_W] = vv[DATA_W-1:0];
    vld = 1'b1;
    tick();
  endtask

  task automatic idle(input int n);
    vld = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    #1 rst = 1'b1;
    #2;
    check("rst_led", 32'(LED), 32'h0);
    check("rst_upd", 32'(led_upd), 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    idle(2);

    // live, channel 1
    ch_sel = 2'd1; idle(1);
    exp_q.push_back(8'h64); sample(200, 1);
    exp_q.push_back(8'h9C); sample(-200, 1);
    exp_q.push_back(8'h7F); sample(340, 1);
    exp_q.push_back(8'h80); sample(-4096, 1);
    idle(2);
    check("live_final", 32'(LED), 32'h80);
    check("live_pulses", 32'(upd_cnt), 32'd4);

    // average with gaps
    mode = 2'd1; ch_sel = 2'd0; idle(1);
    upd_mark = upd_cnt;
    sample(10, 0); idle(2);
    sample(20, 0); idle(1);
    sample(30, 0); idle(3);
    check("avg_hold", 32'(LED), 32'h80);
    check("avg_nopulse", 32'(upd_cnt - upd_mark), 32'd0);
    exp_q.push_back(8'h0C); sample(40, 0); idle(2);
    sample(-1, 0); sample(0, 0); sample(0, 0);
    exp_q.push_back(8'hFF); sample(0, 0); idle(2);
    check("avg_neg", 32'(LED), 32'hFF);

    // peak
    mode = 2'd2; idle(1);
    upd_mark = upd_cnt;
    exp_q.push_back(8'h02); sample(5, 0);
    exp_q.push_back(8'h19); sample(50, 0);
    sample(-300, 0); sample(20, 0); idle(2);
    check("peak_val", 32'(LED), 32'h19);
    check("peak_pulses", 32'(upd_cnt - upd_mark), 32'd2);
    clr_pk = 1'b1;
    exp_q.push_back(8'h0A); sample(20, 0);
    clr_pk = 1'b0; idle(2);
    check("peak_clr", 32'(LED), 32'h0A);

    // channel change mid-average; the coincident sample starts the new block
    mode = 2'd1; ch_sel = 2'd0; idle(1);
    sample(100, 0); sample(100, 0);
    ch_sel = 2'd2;
    sample(8, 2); sample(8, 2); sample(8, 2);
    exp_q.push_back(8'h04); sample(8, 2); idle(2);
    check("chg_avg", 32'(LED), 32'h04);

    // freeze
    mode = 2'd0; ch_sel = 2'd1; idle(1);
    exp_q.push_back(8'h64); sample(200, 1); idle(1);
    mode = 2'd3; idle(1);
    upd_mark = upd_cnt;
    for (int i = 0; i < 10; i++) begin
      sample(int'($urandom_range(4000)) - 2000, 1);
      if (i % 3 == 0) idle(1);
    end
    idle(2);
    check("frz_hold", 32'(LED), 32'h64);
    check("frz_nopulse", 32'(upd_cnt - upd_mark), 32'd0);
    mode = 2'd0; idle(1);
    exp_q.push_back(8'h03); sample(6, 1); idle(2);
    check("frz_exit", 32'(LED), 32'h03);

    // async reset during an average burst
    mode = 2'd1; ch_sel = 2'd0; idle(1);
    sample(50, 0); sample(50, 0);
    data[DATA_W-1:0] = 13'd50; vld = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("arst_led", 32'(LED), 32'h0);
    check("arst_upd", 32'(led_upd), 32'h0);
    vld = 1'b0;
    tick(); tick();
    rst = 1'b0;
    upd_mark = upd_cnt;
    sample(20, 0); sample(20, 0); sample(20, 0); idle(1);
    check("post_rst_hold", 32'(LED), 32'h0);
    check("post_rst_nopulse", 32'(upd_cnt - upd_mark), 32'd0);
    exp_q.push_back(8'h0A); sample(20, 0); idle(3);
    check("post_rst_avg", 32'(LED), 32'h0A);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
